led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Sequences the 4 board LEDs from the 4 slide switches. It debounces the switches and decodes sw[1:0] as pattern mode and sw[3:2] as speed. A timed state machine then steps the LED pattern. It sits between the top-level sw/led pins and is the single owner of the led output in main.

Parameters:
TICK_DIV, 10_000_000, clk cycles per base tick (100 MHz -> 10 Hz); must be >= 2
DEBOUNCE_CYCLES, 1_000_000, consecutive clk cycles a synced switch bit must differ from its stable value before being accepted; must be >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sw  in  4  raw asynchronous slide switches
led  out  4  LED pattern, registered
step_pulse  out  1  one-cycle pulse in the cycle led shows a newly stepped pattern value

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. No other clock or reset.
- Reset: led=0000, step_pulse=0, debounced value=0000, all counters=0, state=STATIC, dir=up. Reset takes priority over every other event, including mid-pattern and mid-debounce.
- Synchroniser: 2-flop per sw bit.
- Debounce, per bit:
  - If synced != stable, the counter increments. If synced == stable, the counter is cleared.
  - When the counter is DEBOUNCE_CYCLES-1 and the mismatch persists, stable <= synced and the counter clears.
  - A clean sw change reaches the stable value DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Decode: mode = stable[1:0], speed = stable[3:2].
- Prescaler: counts 0..TICK_DIV-1 and emits an internal tick on wrap.
- Step counter: counts ticks. A step fires when 2^(3-speed) ticks have elapsed, then the counter clears. Step period = TICK_DIV*2^(3-speed) cycles (speed 3 fastest, speed 0 slowest).
- State machine (state <- mode on change):
  - STATIC (mode 00): led = stable value (echo). No steps and no step_pulse.
  - SHIFT (01): rotate left 0001->0010->0100->1000->0001.
  - BOUNCE_UP / BOUNCE_DOWN (10): walk up to 1000, then reverse to BOUNCE_DOWN and walk to 0001, then reverse again. Ends are not repeated.
  - BLINK (11): toggle 1111 <-> 0000.
- Mode change (stable[1:0] differs from the previous cycle):
  - On the next edge, enter the new state and initialise the pattern: SHIFT/BOUNCE -> 0001 with dir up; BLINK -> 1111; STATIC -> echo.
  - Prescaler and step counter clear. step_pulse = 0 on the init cycle.
  - The first step occurs exactly one step period after the init edge.
- Speed change only (stable[3:2] changes): prescaler and step counter clear; the pattern and state are kept.
- Simultaneous mode change and step: the mode change wins and the step is dropped.
- step_pulse is registered together with led, so it is high exactly in the first cycle of a stepped value.

Decomposition:
- Package led_seq_pkg: mode_e (STATIC, SHIFT, BOUNCE, BLINK; 2 bits), state_e (STATIC, SHIFT, BOUNCE_UP, BOUNCE_DOWN, BLINK), constants LED_INIT=4'b0001, LED_ALL=4'b1111, LED_W=4.
- Sub-module sw_debouncer: parameters WIDTH and DEBOUNCE_CYCLES; contains the synchroniser plus per-bit debounce; ports clk, rst, raw, stable.
- The top holds the prescaler, step counter and FSM.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3, clk 10 ns):
- Reset: sw=0000, rst high for 3 cycles -> led=0000 and step_pulse=0 during reset and for 100 cycles after.
- Debounce: sw=0100 -> led=0100 exactly 5 edges later. Then a 2-cycle glitch sw=0101 followed by a return to 0100 -> led stays 0100, no step_pulse.
- SHIFT at speed 3 (sw=1101) -> led=0001 on the init edge. Then 0010, 0100, 1000, 0001 every 4 cycles, with one step_pulse per change.
- BOUNCE at speed 3 (sw=1110) -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010 at 4-cycle spacing, with no repeated end values.
- BLINK at speed 0 (sw=0011) -> led=1111 for 32 cycles, 0000 for 32 cycles, then 1111.
- Mid-operation: in SHIFT with led=0100, switch to BLINK -> led=1111 on the init edge, first toggle 4 cycles later at speed 3. Then assert rst for 1 cycle -> led=0000 and state=STATIC on the next edge.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the switch-mode decode, the FSM state encoding and the step-length helper.
package led_seq_pkg;

  localparam int unsigned LED_W = 4;
  localparam logic [LED_W-1:0] LED_INIT = 4'b0001;
  localparam logic [LED_W-1:0] LED_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    ModeStatic = 2'b00,
    ModeShift  = 2'b01,
    ModeBounce = 2'b10,
    ModeBlink  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    StStatic,
    StShift,
    StBounceUp,
    StBounceDown,
    StBlink
  } state_e;

  // Last tick index of a step: a step spans 2^(3-speed) ticks.
  function automatic logic [2:0] step_limit(input logic [1:0] speed);
    logic [3:0] ticks;
    ticks = 4'd8 >> speed;
    return 3'(ticks - 4'd1);
  endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Two-flop synchroniser followed by a per-bit debounce counter.
// A bit's stable value only follows the synced input after a sustained mismatch.
module sw_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]           sync1_q, sync2_q;
  logic [WIDTH-1:0]           stable_q, stable_d;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a 4-LED pattern chosen by the debounced switches (sw[1:0] mode, sw[3:2] speed).
// Holds the tick prescaler, the per-speed step counter and the pattern FSM.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 10_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] led,
  output logic             step_pulse
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  logic [LED_W-1:0]  stable;
  mode_e             mode, mode_q;
  logic [1:0]        speed, speed_q;
  logic              mode_chg, speed_chg;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        step_cnt_q, step_cnt_d;
  logic              tick, step;
  state_e            state_q, state_d;
  logic [LED_W-1:0]  led_q, led_d, led_nxt;
  logic              pulse_q, pulse_d;

  sw_debouncer #(
    .WIDTH           (LED_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debouncer (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw),
    .stable (stable)
  );

  assign mode      = mode_e'(stable[1:0]);
  assign speed     = stable[3:2];
  assign mode_chg  = (mode != mode_q);
  assign speed_chg = (speed != speed_q);

  // Any setting change restarts timing, so a step never lands on a change cycle.
  assign tick = (presc_q == PrescMax);
  assign step = tick && (step_cnt_q == step_limit(speed)) && !mode_chg && !speed_chg;

  always_comb begin
    presc_d    = presc_q;
    step_cnt_d = step_cnt_q;
    if (mode_chg || speed_chg) begin
      presc_d    = '0;
      step_cnt_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PrescW'(1);
      if (step) begin
        step_cnt_d = '0;
      end else if (tick) begin
        step_cnt_d = step_cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    pulse_d = 1'b0;
    led_nxt = led_q;
    if (mode_chg) begin
      unique case (mode)
        ModeStatic: begin
          state_d = StStatic;
          led_d   = stable;
        end
        ModeShift: begin
          state_d = StShift;
          led_d   = LED_INIT;
        end
        ModeBounce: begin
          state_d = StBounceUp;
          led_d   = LED_INIT;
        end
        ModeBlink: begin
          state_d = StBlink;
          led_d   = LED_ALL;
        end
      endcase
    end else begin
      unique case (state_q)
        StStatic: led_d = stable;
        StShift: begin
          led_nxt = {led_q[LED_W-2:0], led_q[LED_W-1]};
        end
        StBounceUp: begin
          led_nxt = led_q << 1;
          // Reverse on reaching the top so the end value is shown only once.
          if (step && led_nxt == 4'b1000) state_d = StBounceDown;
        end
        StBounceDown: begin
          led_nxt = led_q >> 1;
          if (step && led_nxt == LED_INIT) state_d = StBounceUp;
        end
        StBlink: begin
          led_nxt = (led_q == LED_ALL) ? '0 : LED_ALL;
        end
        default: state_d = StStatic;
      endcase
      if (step && state_q != StStatic) begin
        led_d   = led_nxt;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= ModeStatic;
      speed_q    <= '0;
      presc_q    <= '0;
      step_cnt_q <= '0;
      state_q    <= StStatic;
      led_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      mode_q     <= mode;
      speed_q    <= speed;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      state_q    <= state_d;
      led_q      <= led_d;
      pulse_q    <= pulse_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus queues the expected (cycle, led, pulse) of every visible
// output change; a monitor pops and compares whenever led changes or step_pulse is high.
module tb_led_pattern_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic       pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] led;
  logic       step_pulse;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  led_pattern_sequencer #(
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .led        (led),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] l, input logic p);
    exp_t e;
    e.cyc   = c;
    e.led   = l;
    e.pulse = p;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: {led,pulse} got %b, want %b", name, cyc, act, want);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every led change or step_pulse is a DUT output event.
  initial begin
    logic [3:0] last_led;
    exp_t       e;
    last_led = 4'b0000;
    forever begin
      @(negedge clk);
      if (mon_en && (led !== last_led || step_pulse !== 1'b0)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event at cycle %0d: led=%b pulse=%b", cyc, led, step_pulse);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.led !== led || e.pulse !== step_pulse) begin
            miscompares++;
            $display("FAIL event: got led=%b pulse=%b at cycle %0d, want led=%b pulse=%b at cycle %0d",
                     led, step_pulse, cyc, e.led, e.pulse, e.cyc);
          end
        end
      end
      last_led = led;
    end
  end

  initial begin
    int   c, i1, i2, i3, i4, i5, c6;
    exp_t e;
    logic [3:0] bseq [7];
    bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    rst = 1'b1;
    sw  = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("reset_state", {led, step_pulse}, 5'b0000_0);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_after_reset", {led, step_pulse}, 5'b0000_0);

    // STATIC echo of a clean change: visible 5 edges after the first sampling edge.
    c = cyc;
    sw = 4'b0100;
    push(c + 6, 4'b0100, 1'b0);
    repeat (12) @(negedge clk);
    // Two-cycle glitch on bit 0 must be swallowed.
    sw = 4'b0101;
    repeat (2) @(negedge clk);
    sw = 4'b0100;
    repeat (20) @(negedge clk);
    check("glitch_ignored", {led, step_pulse}, 5'b0100_0);

    // SHIFT at speed 3.
    c  = cyc;
    sw = 4'b1101;
    i1 = c + 6;
    push(i1,      4'b0001, 1'b0);
    push(i1 + 4,  4'b0010, 1'b1);
    push(i1 + 8,  4'b0100, 1'b1);
    push(i1 + 12, 4'b1000, 1'b1);
    push(i1 + 16, 4'b0001, 1'b1);

    // BOUNCE init lands on a would-be step edge; the mode change wins (led stays 0001).
    wait_until(i1 + 14);
    sw = 4'b1110;
    i2 = i1 + 20;
    for (int k = 0; k < 7; k++) push(i2 + 4 * (k + 1), bseq[k], 1'b1);

    // BLINK at speed 0, again colliding with a bounce step.
    wait_until(i2 + 26);
    sw = 4'b0011;
    i3 = i2 + 32;
    push(i3,      4'b1111, 1'b0);
    push(i3 + 32, 4'b0000, 1'b1);
    push(i3 + 64, 4'b1111, 1'b1);

    // Back to SHIFT, then switch to BLINK while led=0100.
    wait_until(i3 + 74);
    sw = 4'b1101;
    i4 = i3 + 80;
    push(i4,     4'b0001, 1'b0);
    push(i4 + 4, 4'b0010, 1'b1);
    push(i4 + 8, 4'b0100, 1'b1);
    wait_until(i4 + 4);
    sw = 4'b1111;
    i5 = i4 + 10;
    push(i5,     4'b1111, 1'b0);
    push(i5 + 4, 4'b0000, 1'b1);
    push(i5 + 8, 4'b1111, 1'b1);

    // One-cycle reset mid-pattern.
    wait_until(i5 + 9);
    rst = 1'b1;
    sw  = 4'b0000;
    push(i5 + 10, 4'b0000, 1'b0);
    wait_until(i5 + 10);
    rst = 1'b0;

    // After reset the FSM is STATIC: a new switch value is simply echoed.
    wait_until(i5 + 30);
    c6 = cyc;
    sw = 4'b1000;
    push(c6 + 6, 4'b1000, 1'b0);
    wait_until(c6 + 30);
    check("static_after_reset", {led, step_pulse}, 5'b1000_0);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: want led=%b pulse=%b at cycle %0d, never seen",
               e.led, e.pulse, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
